// File: rtl/player_input_ctrl.sv
// Player input front-end: key sync/debounce, move request latch, one command per frame.
// Optional held-key auto-repeat is built when AUTO_REPEAT_EN is defined.
module player_input_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int FRAME_HZ        = 60,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_FRAMES   = 8,
    parameter int BUSY_TIMEOUT    = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_up_n,
    input  logic key_down_n,
    input  logic continue_draw,
    output logic up,
    output logic down,
    output logic draw_enable,
    output logic frame_tick,
    output logic busy
);

    localparam int DIV   = CLK_HZ / FRAME_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Bit 0 is the up key, bit 1 the down key throughout.
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            raw;
    logic [1:0]            stable;
    logic [1:0]            stable_d;
    logic [1:0]            press;
    logic [1:0][DEB_W-1:0] deb_cnt;

    logic [DIV_W-1:0]      div_cnt;
    logic                  div_last;

    logic [1:0]            rpt_fire;
    logic [1:0]            req_q;
    logic [1:0]            req_d;
    logic [1:0]            issue;

    state_t                state_q;
    state_t                state_d;
    logic [TO_W-1:0]       to_cnt_q;
    logic [TO_W-1:0]       to_cnt_d;
    logic                  to_last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {key_down_n, key_up_n};
            sync2 <= sync1;
        end
    end

    assign raw = ~sync2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable  <= 2'b00;
            deb_cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (raw[k] == stable[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[k]  <= ~stable[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_d <= 2'b00;
        end else begin
            stable_d <= stable;
        end
    end

    assign press = stable & ~stable_d;

    assign div_last = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= div_last;
            if (div_last) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_FRAMES + 1);

    logic [1:0][RPT_W-1:0] rpt_cnt;

    // A held key counts whole frames from its press edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rpt_cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!stable[k] || press[k]) begin
                    rpt_cnt[k] <= '0;
                end else if (frame_tick) begin
                    if (rpt_cnt[k] == RPT_W'(REPEAT_FRAMES - 1)) begin
                        rpt_cnt[k] <= '0;
                    end else begin
                        rpt_cnt[k] <= rpt_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rpt_fire = 2'b00;
        for (int k = 0; k < 2; k++) begin
            rpt_fire[k] = stable[k] && !press[k] && frame_tick &&
                          (rpt_cnt[k] == RPT_W'(REPEAT_FRAMES - 1));
        end
    end
`else
    assign rpt_fire = 2'b00;
`endif

    assign to_last = (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        req_d    = req_q;
        issue    = 2'b00;
        unique case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    unique case (req_q)
                        2'b01, 2'b10: begin
                            issue   = req_q;
                            req_d   = 2'b00;
                            state_d = S_BUSY;
                        end
                        // Conflicting requests cancel each other.
                        2'b11:   req_d = 2'b00;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (continue_draw || to_last) begin
                    state_d  = S_IDLE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        endcase
        req_d = req_d | press | rpt_fire;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= '0;
            req_q       <= 2'b00;
            draw_enable <= 1'b0;
            up          <= 1'b0;
            down        <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            req_q       <= req_d;
            draw_enable <= |issue;
            up          <= issue[0];
            down        <= issue[1];
        end
    end

    assign busy = (state_q == S_BUSY);

endmodule

// File: doc/player_input_ctrl.md
Name: player_input_ctrl

Overview:
Upstream front-end for the player-ship draw FSM. Conditions the raw push-button inputs: synchronises, debounces and latches a move request. Issues exactly one single-cycle up/down plus draw_enable command per 60 Hz frame. Holds off further commands until the FSM signals completion on continue_draw.

Parameters:
CLK_HZ, 50000000, system clock frequency
FRAME_HZ, 60, command issue rate; frame divider DIV = CLK_HZ/FRAME_HZ (integer, >= 2)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a key change
REPEAT_FRAMES, 8, frames between auto-repeats (used only with AUTO_REPEAT_EN)
BUSY_TIMEOUT, 16, cycles after issue before busy self-clears without continue_draw

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
key_up_n  in  1  raw asynchronous up button, active-low
key_down_n  in  1  raw asynchronous down button, active-low
continue_draw  in  1  FSM draw-complete pulse
up  out  1  move-up command, valid with draw_enable
down  out  1  move-down command, valid with draw_enable
draw_enable  out  1  single-cycle command strobe to the FSM
frame_tick  out  1  single-cycle frame pulse
busy  out  1  command outstanding

Behaviour:
- Reset (reset_n=0 at a clk edge) clears all state:
  - up, down, draw_enable, frame_tick and busy go to 0.
  - Synchroniser flops go to 1 (released); debounced state goes to released.
  - All counters go to 0; pending requests are cleared.
  - Reset mid-command abandons the command. continue_draw arriving after reset is ignored.
- Synchroniser: 2 flops per key, then inverted to give an active-high pressed signal.
- Debounce, per key:
  - The counter increments while the synchronised value differs from the stable state. It clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable state toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the stable state.
- Frame divider:
  - Counter runs 0..DIV-1 and wraps to 0.
  - frame_tick=1 (registered) in the cycle after the counter equals DIV-1. Exactly one cycle per DIV cycles.
- Request latch:
  - A stable released->pressed edge sets req_up or req_down.
  - A pending request persists across ticks until it is issued or cancelled.
  - A second press before issue has no additional effect; requests do not queue.
- Issue, evaluated in cycles where frame_tick=1:
  - If busy=1: nothing is issued and requests are retained.
  - Else if exactly one request is pending: the next cycle has draw_enable=1 with up=1 (or down=1) for exactly one cycle. busy is set in that same cycle and the request is cleared.
  - Else if both requests are pending: both are cleared and nothing is issued.
  - up and down are 0 whenever draw_enable=0; they are never both 1.
- Busy:
  - Cleared in the cycle after continue_draw=1 is sampled while busy=1.
  - continue_draw while busy=0 is ignored.
  - Timeout counter runs while busy. After BUSY_TIMEOUT cycles without continue_draw, busy clears and the counter resets.
  - continue_draw and timeout in the same cycle: busy clears once, with no side effects.
- Latency: key press -> request pending at DEBOUNCE_CYCLES+3 cycles. Pending -> draw_enable on the cycle after the next frame_tick where busy=0.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - While a key's stable state is pressed, a per-key repeat counter counts frame_ticks.
  - On reaching REPEAT_FRAMES, it re-sets that key's request and clears.
  - The counter clears on release and on the initial press.
  - Holding both keys is resolved by the both-pending rule: both requests are cancelled.
- Undefined: only press edges create requests; a held key yields exactly one move. The repeat logic is absent.

Test Plan:
Bench params: CLK_HZ=600, FRAME_HZ=60 (DIV=10), DEBOUNCE_CYCLES=4, BUSY_TIMEOUT=16, REPEAT_FRAMES=3.
1. Reset, including mid-command (assert reset the cycle after draw_enable) -> all outputs 0. frame_tick first pulses 10 cycles after release, then every 10 cycles. Stale continue_draw leaves busy=0.
2. key_up_n low for 20 cycles -> exactly one draw_enable=1 with up=1, down=0, in the cycle after the first frame_tick following debounce. busy=1 from that cycle. A continue_draw pulse 6 cycles later -> busy=0 the next cycle.
3. key_down_n glitch low for 3 cycles -> no request. Held low for 5+ cycles -> one down command.
4. Press up, then press down before the next tick -> both cancelled; no draw_enable at that tick or later.
5. Issue a command and withhold continue_draw -> busy stays 1 for 16 cycles then clears. A request pending at an intermediate tick issues at the first tick after busy clears.
6. AUTO_REPEAT_EN, up held for 10 frames, continue_draw returned each time -> commands at the first tick after press, then every 3 ticks. Without the macro -> exactly one command.
